// File: rtl/spi_burst_arbiter_pkg.sv
// Shared types and constants for the two-port SPI burst arbiter.
// Holds FSM state encodings, port indices and the default chip-select gap.
package spi_burst_arbiter_pkg;

  localparam int unsigned CLK_FREQ       = 50_000_000;
  localparam int unsigned CS_GAP_DEFAULT = 4;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // One byte as presented to the SPI engine: D/C flag plus data.
  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } spi_byte_t;

  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/spi_burst_arbiter_rr_arb2.sv
// Two-way round-robin pick: combinational, returns the one-hot winner.
// On contention the port that did not own the engine last time wins.
module spi_burst_arbiter_rr_arb2
  import spi_burst_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] pick_c
);

  always_comb begin
    pick_c = 2'b00;
    case (req)
      2'b01:   pick_c = port_onehot(PORT0);
      2'b10:   pick_c = port_onehot(PORT1);
      2'b11:   pick_c = port_onehot((last_grant == PORT0) ? PORT1 : PORT0);
      default: pick_c = 2'b00;
    endcase
  end

endmodule

// File: rtl/spi_burst_arbiter.sv
// Shares one SPI byte engine between two burst requesters, round-robin,
// holding chip-select for a whole burst. Optional per-byte watchdog: SPI_ARB_WATCHDOG_EN.
module spi_burst_arbiter
  import spi_burst_arbiter_pkg::*;
#(
  parameter int unsigned CS_GAP  = CS_GAP_DEFAULT,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  input  logic [7:0]       data0,
  input  logic [7:0]       data1,
  input  logic             dc0,
  input  logic             dc1,
  output logic [1:0]       next,
  output logic [1:0]       done,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             spi_onoff,
  output logic [7:0]       spi_data,
  output logic             spi_dc,
  input  logic             spi_valid,
  output logic             err
);

  localparam int unsigned      GAP_W    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  if (CS_GAP < 1 || TIMEOUT < 2) begin : g_bad_cfg
    $error("spi_burst_arbiter: CS_GAP must be >= 1 and TIMEOUT >= 2");
  end

  state_t           state;
  logic             last_grant;
  logic [LEN_W-1:0] cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [1:0]       pick;
  logic             pick_idx;
  logic [LEN_W-1:0] pick_len;
  logic             sel_idx;
  spi_byte_t        sel_byte;

  spi_burst_arbiter_rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_grant),
    .pick_c     (pick)
  );

  assign pick_idx = pick[1] ? PORT1 : PORT0;
  assign pick_len = pick[1] ? len1 : len0;

  // In ARB the fresh winner supplies the first byte; afterwards the owner does.
  assign sel_idx  = (state == ST_ARB) ? pick_idx : last_grant;
  assign sel_byte = (sel_idx == PORT1) ? {dc1, data1} : {dc0, data0};

`ifdef SPI_ARB_WATCHDOG_EN
  localparam int unsigned     WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_fire;

  assign wd_fire = (wd_cnt == WD_LAST);
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      last_grant <= PORT1;
      cnt        <= '0;
      gap_cnt    <= '0;
      grant      <= '0;
      next       <= '0;
      done       <= '0;
      busy       <= 1'b0;
      spi_onoff  <= 1'b0;
      spi_data   <= '0;
      spi_dc     <= 1'b0;
`ifdef SPI_ARB_WATCHDOG_EN
      wd_cnt     <= '0;
      err        <= 1'b0;
`endif
    end else begin
      next <= '0;
      done <= '0;
`ifdef SPI_ARB_WATCHDOG_EN
      err  <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (|req) begin
            state <= ST_ARB;
            busy  <= 1'b1;
          end
        end

        ST_ARB: begin
          if (pick == 2'b00) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            last_grant <= pick_idx;
            cnt        <= pick_len;
            if (pick_len == '0) begin
              // Empty burst: finish without ever raising chip-select.
              done  <= pick;
              grant <= '0;
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              grant     <= pick;
              spi_data  <= sel_byte.data;
              spi_dc    <= sel_byte.dc;
              next      <= pick;
              spi_onoff <= 1'b1;
              state     <= ST_SEND;
`ifdef SPI_ARB_WATCHDOG_EN
              wd_cnt    <= '0;
`endif
            end
          end
        end

        ST_SEND: begin
          if (spi_valid) begin
`ifdef SPI_ARB_WATCHDOG_EN
            wd_cnt <= '0;
`endif
            if (cnt > LEN_ONE) begin
              cnt      <= cnt - LEN_ONE;
              spi_data <= sel_byte.data;
              spi_dc   <= sel_byte.dc;
              next     <= grant;
            end else begin
              done      <= grant;
              spi_onoff <= 1'b0;
              grant     <= '0;
              gap_cnt   <= '0;
              state     <= ST_GAP;
            end
          end
`ifdef SPI_ARB_WATCHDOG_EN
          else if (wd_fire) begin
            // Engine stalled on this byte: abandon the burst.
            err       <= 1'b1;
            done      <= grant;
            spi_onoff <= 1'b0;
            grant     <= '0;
            gap_cnt   <= '0;
            state     <= ST_GAP;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
`endif
        end

        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_burst_arbiter.sv
// Directed self-checking bench for spi_burst_arbiter with a simple engine
// and requester model; covers the watchdog when SPI_ARB_WATCHDOG_EN is defined.
module tb_spi_burst_arbiter;

  localparam int unsigned LEN_W      = 8;
  localparam int unsigned CS_GAP     = 4;
  localparam int unsigned TIMEOUT    = 16;
  localparam int          ENG_PERIOD = 40;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [1:0]       req = 2'b00;
  logic [LEN_W-1:0] len0 = '0, len1 = '0;
  logic [7:0]       data0 = '0, data1 = '0;
  logic             dc0 = 1'b0, dc1 = 1'b0;
  logic [1:0]       next, done, grant;
  logic             busy, spi_onoff, spi_dc, err;
  logic [7:0]       spi_data;
  logic             spi_valid = 1'b0;

  spi_burst_arbiter #(
    .CS_GAP  (CS_GAP),
    .LEN_W   (LEN_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .len0      (len0),
    .len1      (len1),
    .data0     (data0),
    .data1     (data1),
    .dc0       (dc0),
    .dc1       (dc1),
    .next      (next),
    .done      (done),
    .grant     (grant),
    .busy      (busy),
    .spi_onoff (spi_onoff),
    .spi_data  (spi_data),
    .spi_dc    (spi_dc),
    .spi_valid (spi_valid),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [8:0] pbytes [2][8];
  int         pidx [2];
  int         n_next [2];
  int         n_done [2];
  int         done_cyc [2];
  int         n_err, err_cyc, n_rise, n_fall, rise_cyc, low_run, min_gap, last_valid_cyc;
  bit         seen_fall = 1'b0;
  bit         prev_onoff = 1'b0;
  bit         eng_en = 1'b1;
  int         eng_cnt = 0;
  logic [1:0] prev_grant = 2'b00;
  logic [8:0] cap [$];
  logic [1:0] glog [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_port(input int p);
    logic [8:0] b;
    b = (pidx[p] < 8) ? pbytes[p][pidx[p]] : 9'h000;
    if (p == 0) {dc0, data0} = b;
    else        {dc1, data1} = b;
  endtask

  task automatic load(input int p, input int len,
                      input logic [8:0] b0, input logic [8:0] b1,
                      input logic [8:0] b2, input logic [8:0] b3);
    pbytes[p][0] = b0; pbytes[p][1] = b1; pbytes[p][2] = b2; pbytes[p][3] = b3;
    for (int i = 4; i < 8; i++) pbytes[p][i] = 9'h000;
    pidx[p] = 0;
    drive_port(p);
    if (p == 0) len0 = 8'(len);
    else        len1 = 8'(len);
  endtask

  task automatic clear_stats();
    for (int p = 0; p < 2; p++) begin
      n_next[p] = 0; n_done[p] = 0; done_cyc[p] = 0;
    end
    n_err = 0; err_cyc = 0; n_rise = 0; n_fall = 0; rise_cyc = 0;
    min_gap = 1000; last_valid_cyc = 0; seen_fall = 1'b0;
    cap.delete();
    glog.delete();
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int p, input int n, input int budget, input string tag);
    int k = 0;
    while (n_done[p] < n && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_wait"}, 32'(n_done[p] >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((busy || req != 2'b00) && k < budget) begin
      tick();
      k++;
    end
    check("idle_wait", 32'(busy), 32'd0);
  endtask

  // Observe outputs, then play requester and engine, all on the falling edge.
  initial begin : monitor
    forever begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        if (next[p] === 1'b1) begin
          n_next[p]++;
          pidx[p]++;
          drive_port(p);
        end
        if (done[p] === 1'b1) begin
          n_done[p]++;
          done_cyc[p] = cyc;
          req[p] = 1'b0;
        end
      end
      if (err === 1'b1) begin
        n_err++;
        err_cyc = cyc;
      end
      if (grant != 2'b00 && grant != prev_grant) glog.push_back(grant);
      prev_grant = grant;
      if (spi_onoff && !prev_onoff) begin
        n_rise++;
        rise_cyc = cyc;
        if (seen_fall && low_run < min_gap) min_gap = low_run;
      end
      if (!spi_onoff && prev_onoff) begin
        n_fall++;
        seen_fall = 1'b1;
      end
      low_run = spi_onoff ? 0 : low_run + 1;
      prev_onoff = spi_onoff;
      if (eng_en && spi_onoff === 1'b1) begin
        eng_cnt++;
        if (eng_cnt >= ENG_PERIOD) begin
          spi_valid = 1'b1;
          eng_cnt = 0;
          cap.push_back({spi_dc, spi_data});
          last_valid_cyc = cyc;
        end else begin
          spi_valid = 1'b0;
        end
      end else begin
        eng_cnt = 0;
        spi_valid = 1'b0;
      end
    end
  end

  initial begin : guard
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin : main
    clear_stats();
    // Reset held with both ports requesting, then release into contention.
    load(0, 2, 9'h011, 9'h122, 9'h000, 9'h000);
    load(1, 2, 9'h133, 9'h044, 9'h000, 9'h000);
    req = 2'b11;
    repeat (5) tick();
    check("rst_onoff", 32'(spi_onoff), 32'd0);
    check("rst_data",  32'(spi_data),  32'd0);
    check("rst_dc",    32'(spi_dc),    32'd0);
    check("rst_next",  32'(next),      32'd0);
    check("rst_done",  32'(done),      32'd0);
    check("rst_grant", 32'(grant),     32'd0);
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_err",   32'(err),       32'd0);
    reset = 1'b1;
    repeat (2) tick();
    check("rel_grant", 32'(grant),     32'd1);
    check("rel_onoff", 32'(spi_onoff), 32'd1);
    wait_done(1, 1, 2000, "t1_done1");
    wait_idle(50);
    check("t1_glog_n", 32'(glog.size()), 32'd2);
    check("t1_glog0",  32'(glog[0]),     32'd1);
    check("t1_glog1",  32'(glog[1]),     32'd2);
    check("t1_cap0",   32'(cap[0]),      32'h011);
    check("t1_cap1",   32'(cap[1]),      32'h122);
    check("t1_cap2",   32'(cap[2]),      32'h133);
    check("t1_cap3",   32'(cap[3]),      32'h044);
    check("t1_next0",  32'(n_next[0]),   32'd2);
    check("t1_next1",  32'(n_next[1]),   32'd2);
    check("t1_done0",  32'(n_done[0]),   32'd1);
    check("t1_gap",    32'(min_gap >= CS_GAP), 32'd1);

    // Re-request both: port 1 owned last, so port 0 goes first again.
    clear_stats();
    load(0, 2, 9'h001, 9'h002, 9'h000, 9'h000);
    load(1, 2, 9'h003, 9'h004, 9'h000, 9'h000);
    req = 2'b11;
    wait_done(1, 1, 2000, "t3_done1");
    wait_idle(50);
    check("t3_glog0", 32'(glog[0]), 32'd1);
    check("t3_glog1", 32'(glog[1]), 32'd2);

    // Single three-byte burst on port 0.
    clear_stats();
    load(0, 3, 9'h0A5, 9'h03C, 9'h0FF, 9'h000);
    req = 2'b01;
    wait_done(0, 1, 2000, "t2_done0");
    check("t2_done_lat", 32'(done_cyc[0] - last_valid_cyc), 32'd1);
    wait_idle(50);
    check("t2_cap_n",  32'(cap.size()), 32'd3);
    check("t2_cap0",   32'(cap[0]),     32'h0A5);
    check("t2_cap1",   32'(cap[1]),     32'h03C);
    check("t2_cap2",   32'(cap[2]),     32'h0FF);
    check("t2_rise",   32'(n_rise),     32'd1);
    check("t2_fall",   32'(n_fall),     32'd1);
    check("t2_next0",  32'(n_next[0]),  32'd3);
    check("t2_done_n", 32'(n_done[0]),  32'd1);

    // Port 0 owned last: contention now serves port 1 first.
    clear_stats();
    load(0, 2, 9'h111, 9'h022, 9'h000, 9'h000);
    load(1, 2, 9'h055, 9'h166, 9'h000, 9'h000);
    req = 2'b11;
    wait_done(0, 1, 2000, "t4_done0");
    wait_idle(50);
    check("t4_glog0", 32'(glog[0]), 32'd2);
    check("t4_glog1", 32'(glog[1]), 32'd1);
    check("t4_cap0",  32'(cap[0]),  32'h055);
    check("t4_cap2",  32'(cap[2]),  32'h111);
    check("t4_gap",   32'(min_gap >= CS_GAP), 32'd1);

    // Zero-length burst on port 1.
    begin
      int t0;
      clear_stats();
      load(1, 0, 9'h0EE, 9'h000, 9'h000, 9'h000);
      t0 = cyc;
      req = 2'b10;
      wait_done(1, 1, 20, "t5_done1");
      check("t5_done_lat", 32'(done_cyc[1] - t0), 32'd2);
      repeat (5) tick();
      check("t5_rise",  32'(n_rise),    32'd0);
      check("t5_next1", 32'(n_next[1]), 32'd0);
      check("t5_busy",  32'(busy),      32'd0);
    end

    // Reset in the middle of a four-byte burst.
    begin
      int k = 0;
      clear_stats();
      load(0, 4, 9'h0C1, 9'h0C2, 9'h0C3, 9'h0C4);
      req = 2'b01;
      while (n_next[0] < 2 && k < 500) begin
        tick();
        k++;
      end
      check("t6_byte2_wait", 32'(n_next[0] >= 2), 32'd1);
      repeat (10) tick();
      #2 reset = 1'b0;
      #1;
      check("t6_async_onoff", 32'(spi_onoff), 32'd0);
      check("t6_async_grant", 32'(grant),     32'd0);
      req = 2'b00;
      repeat (3) tick();
      reset = 1'b1;
      repeat (12) tick();
      check("t6_busy",  32'(busy),      32'd0);
      check("t6_done",  32'(n_done[0]), 32'd0);
      check("t6_onoff", 32'(spi_onoff), 32'd0);
      check("t6_rise",  32'(n_rise),    32'd1);
    end

    // Stalled engine.
    clear_stats();
    eng_en = 1'b0;
    load(0, 2, 9'h077, 9'h088, 9'h000, 9'h000);
    req = 2'b01;
`ifdef SPI_ARB_WATCHDOG_EN
    begin
      int k = 0;
      while (n_err == 0 && k < 200) begin
        tick();
        k++;
      end
      check("t7_err_wait", 32'(n_err), 32'd1);
      check("t7_err_lat",  32'(err_cyc - rise_cyc), 32'(TIMEOUT));
      check("t7_done_at",  32'(done_cyc[0]), 32'(err_cyc));
      check("t7_done_n",   32'(n_done[0]), 32'd1);
      check("t7_onoff",    32'(spi_onoff), 32'd0);
      check("t7_next0",    32'(n_next[0]), 32'd1);
      wait_idle(50);
    end
`else
    repeat (100) tick();
    check("t7_hold_onoff", 32'(spi_onoff), 32'd1);
    check("t7_no_err",     32'(n_err),     32'd0);
    check("t7_done_none",  32'(n_done[0]), 32'd0);
    eng_en = 1'b1;
    wait_done(0, 1, 500, "t7_done0");
    wait_idle(50);
    check("t7_next0", 32'(n_next[0]), 32'd2);
`endif
    eng_en = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
    $finish;
  end

endmodule
